// File: rtl/turing_machine_pkg.sv
// Shared types and constants for the front-panel Turing machine.
// Table entries are 4-bit words: write symbol, move direction, next state.
package turing_machine_pkg;

   typedef enum logic [1:0] {
      PH_PROG = 2'b00,
      PH_RUN  = 2'b01,
      PH_HALT = 2'b10
   } phase_t;

   localparam int ENTRY_W   = 4;
   localparam int F_WRITE   = 0;
   localparam int F_MOVE    = 1;
   localparam int F_NEXT_LO = 2;
   localparam int F_NEXT_HI = 3;

   // Default for every unprogrammed row: go to halt, write 0, move left.
   localparam logic [ENTRY_W-1:0] HALT_ENTRY = 4'b1100;

   // Any next-state index at or beyond the last state stops the machine.
   function automatic logic is_halt(input logic [1:0] next_state, input int num_states);
      return ({30'd0, next_state} >= 32'(num_states - 1));
   endfunction

endpackage

// File: rtl/turing_machine_if.sv
// Front-panel bundle: table-entry inputs, buttons, LED window and debug taps.
// The panel side uses master, the machine uses slave.
interface turing_machine_if #(
   parameter int TAPE_LEN = 64
);
   localparam int HEAD_W = $clog2(TAPE_LEN);

   logic [3:0]        input_data;
   logic              Next;
   logic              Done;
   logic [10:0]       display_out;
   logic              Compute_done;
   logic [3:0]        currState;
   logic              display_in;
   logic              tape_reg_out;
   logic              data_reg_out;
   logic [HEAD_W-1:0] next_state_out;

   modport master (
      output input_data, Next, Done,
      input  display_out, Compute_done, currState, display_in,
             tape_reg_out, data_reg_out, next_state_out
   );

   modport slave (
      input  input_data, Next, Done,
      output display_out, Compute_done, currState, display_in,
             tape_reg_out, data_reg_out, next_state_out
   );

endinterface

// File: rtl/turing_machine_button_edge.sv
// Rising-edge detector for a level button; a button already high when
// reset releases is seen as a fresh press because the history resets to 0.
module turing_machine_button_edge (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic rise
);

   logic button_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         button_q <= 1'b0;
      end else begin
         button_q <= button;
      end
   end

   assign rise = button & ~button_q;

endmodule

// File: rtl/turing_machine.sv
// Two-symbol, single-tape Turing machine: table is keyed in word by word,
// then each Next press runs one step. LEDs show an 11-cell window on the head.
module turing_machine
   import turing_machine_pkg::*;
#(
   parameter int NUM_STATES = 4,
   parameter int TAPE_LEN   = 64
) (
   input  logic             clock,
   input  logic             reset,
   turing_machine_if.slave  bus
);

   localparam int HEAD_W      = $clog2(TAPE_LEN);
   localparam int NUM_ENTRIES = 2 * (NUM_STATES - 1);
   localparam int PTR_W       = $clog2(NUM_ENTRIES + 1);
   localparam logic [HEAD_W-1:0] HEAD_INIT = HEAD_W'(TAPE_LEN / 2);

   phase_t               phase_reg;
   logic [1:0]           tm_state_reg;
   logic [PTR_W-1:0]     prog_ptr_reg;
   logic [HEAD_W-1:0]    head_reg;
   logic [TAPE_LEN-1:0]  tape_reg;
   logic [ENTRY_W-1:0]   entry_table_reg [NUM_ENTRIES];

   logic                 next_rise;
   logic                 read_sym;
   logic [2:0]           entry_idx;
   logic [ENTRY_W-1:0]   cur_entry;
   logic                 store_en;
   logic                 step_en;

   turing_machine_button_edge u_next_edge (
      .clock  (clock),
      .reset  (reset),
      .button (bus.Next),
      .rise   (next_rise)
   );

   assign read_sym  = tape_reg[head_reg];
   assign entry_idx = {tm_state_reg, read_sym};
   assign store_en  = (phase_reg == PH_PROG) && next_rise &&
                      (prog_ptr_reg < PTR_W'(NUM_ENTRIES));
   assign step_en   = (phase_reg == PH_RUN) && next_rise;

   // The halt state has no rows, so its lookup falls back to the halt word.
   always_comb begin
      cur_entry = HALT_ENTRY;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (entry_idx == 3'(i)) begin
            cur_entry = entry_table_reg[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_table_reg[i] <= HALT_ENTRY;
         end
      end else if (store_en) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (prog_ptr_reg == PTR_W'(i)) begin
               entry_table_reg[i] <= bus.input_data;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tape_reg <= '0;
      end else if (step_en) begin
         tape_reg[head_reg] <= cur_entry[F_WRITE];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase_reg    <= PH_PROG;
         tm_state_reg <= 2'd0;
         prog_ptr_reg <= '0;
         head_reg     <= HEAD_INIT;
      end else begin
         case (phase_reg)
            PH_PROG: begin
               if (store_en) begin
                  prog_ptr_reg <= prog_ptr_reg + 1'b1;
               end
               if (bus.Done) begin
                  phase_reg <= PH_RUN;
               end
            end
            PH_RUN: begin
               if (next_rise) begin
                  // Head arithmetic wraps naturally at the power-of-two tape length.
                  head_reg     <= cur_entry[F_MOVE] ? head_reg + 1'b1 : head_reg - 1'b1;
                  tm_state_reg <= cur_entry[F_NEXT_HI:F_NEXT_LO];
                  if (is_halt(cur_entry[F_NEXT_HI:F_NEXT_LO], NUM_STATES)) begin
                     phase_reg <= PH_HALT;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Window bit gi shows the cell at head + (5 - gi), wrapped around the tape.
   for (genvar gi = 0; gi < 11; gi++) begin : g_window
      localparam int OFS = (TAPE_LEN + 5 - gi) % TAPE_LEN;
      logic [HEAD_W-1:0] win_idx;
      assign win_idx             = head_reg + HEAD_W'(OFS);
      assign bus.display_out[gi] = tape_reg[win_idx];
   end

   assign bus.Compute_done   = (phase_reg == PH_HALT);
   assign bus.currState      = {phase_reg, tm_state_reg};
   assign bus.display_in     = read_sym;
   assign bus.tape_reg_out   = cur_entry[F_WRITE];
   assign bus.data_reg_out   = cur_entry[F_MOVE];
   assign bus.next_state_out = head_reg;

endmodule

// File: tb/tb_turing_machine.sv
// Directed bench for turing_machine: busy beaver, halt freeze, held button,
// head wrap-around and asynchronous reset during a run.
module tb_turing_machine;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   turing_machine_if #(.TAPE_LEN(64)) bus ();

   turing_machine #(
      .NUM_STATES (4),
      .TAPE_LEN   (64)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic press_next();
      @(negedge clock) bus.Next = 1'b1;
      @(negedge clock) bus.Next = 1'b0;
   endtask

   task automatic press_done();
      @(negedge clock) bus.Done = 1'b1;
      @(negedge clock) bus.Done = 1'b0;
   endtask

   task automatic enter_word(input logic [3:0] w);
      bus.input_data = w;
      press_next();
   endtask

   task automatic do_reset();
      bus.Next = 1'b0;
      bus.Done = 1'b0;
      reset    = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   logic [10:0] bb_win [6] = '{11'h040, 11'h030, 11'h018, 11'h01C, 11'h078, 11'h0F0};
   logic [3:0]  bb_prog [4] = '{4'd7, 4'd5, 4'd1, 4'd15};

   initial begin
      bus.input_data = 4'd0;
      bus.Next       = 1'b0;
      bus.Done       = 1'b0;

      // Reset values while reset is held low
      #12;
      check_val("rst_display", 32'(bus.display_out), 32'h000);
      check_val("rst_done", 32'(bus.Compute_done), 32'd0);
      check_val("rst_currstate", 32'(bus.currState), 32'd0);
      check_val("rst_head", 32'(bus.next_state_out), 32'd32);
      check_val("rst_entry_write", 32'(bus.tape_reg_out), 32'd0);
      check_val("rst_entry_move", 32'(bus.data_reg_out), 32'd0);
      @(negedge clock) reset = 1'b1;

      // Busy beaver
      for (int i = 0; i < 4; i++) enter_word(bb_prog[i]);
      press_done();
      check_val("bb_run_phase", 32'(bus.currState), 32'h4);
      check_val("bb_run_display", 32'(bus.display_out), 32'h000);
      check_val("bb_a0_write", 32'(bus.tape_reg_out), 32'd1);
      check_val("bb_a0_move", 32'(bus.data_reg_out), 32'd1);
      for (int i = 0; i < 6; i++) begin
         press_next();
         check_val($sformatf("bb_step%0d_display", i + 1), 32'(bus.display_out), 32'(bb_win[i]));
         check_val($sformatf("bb_step%0d_done", i + 1), 32'(bus.Compute_done), (i == 5) ? 32'd1 : 32'd0);
      end
      check_val("bb_halt_head", 32'(bus.next_state_out), 32'd32);
      check_val("bb_halt_currstate", 32'(bus.currState), 32'hB);

      // Frozen after halt
      repeat (3) press_next();
      press_done();
      check_val("frozen_display", 32'(bus.display_out), 32'h0F0);
      check_val("frozen_done", 32'(bus.Compute_done), 32'd1);
      check_val("frozen_head", 32'(bus.next_state_out), 32'd32);

      // Next held high stores exactly one word (A0 -> B); B0 then keeps its halt default
      do_reset();
      bus.input_data = 4'b0111;
      @(negedge clock) bus.Next = 1'b1;
      repeat (6) @(negedge clock);
      bus.Next = 1'b0;
      bus.input_data = 4'b0000;
      check_val("hold_entry_write", 32'(bus.tape_reg_out), 32'd1);
      check_val("hold_entry_move", 32'(bus.data_reg_out), 32'd1);
      check_val("hold_prog_phase", 32'(bus.currState), 32'h0);
      press_done();
      check_val("hold_run_phase", 32'(bus.currState), 32'h4);
      press_next();
      check_val("hold_step1_display", 32'(bus.display_out), 32'h040);
      check_val("hold_step1_head", 32'(bus.next_state_out), 32'd33);
      check_val("hold_step1_done", 32'(bus.Compute_done), 32'd0);
      press_next();
      check_val("hold_step2_done", 32'(bus.Compute_done), 32'd1);
      check_val("hold_step2_display", 32'(bus.display_out), 32'h020);
      check_val("hold_step2_head", 32'(bus.next_state_out), 32'd32);
      check_val("hold_step2_currstate", 32'(bus.currState), 32'hB);

      // Walk left writing 1s until the head wraps past 0
      do_reset();
      enter_word(4'b0001);
      press_done();
      repeat (32) press_next();
      check_val("wrap32_head", 32'(bus.next_state_out), 32'd0);
      check_val("wrap32_display", 32'(bus.display_out), 32'h01F);
      press_next();
      check_val("wrap33_head", 32'(bus.next_state_out), 32'd63);
      check_val("wrap33_display", 32'(bus.display_out), 32'h01F);
      check_val("wrap33_under_head", 32'(bus.display_in), 32'd0);
      check_val("wrap33_done", 32'(bus.Compute_done), 32'd0);
      check_val("wrap33_currstate", 32'(bus.currState), 32'h4);

      // Asynchronous reset in the middle of a run, sampled between clock edges
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check_val("async_display", 32'(bus.display_out), 32'h000);
      check_val("async_done", 32'(bus.Compute_done), 32'd0);
      check_val("async_currstate", 32'(bus.currState), 32'd0);
      check_val("async_head", 32'(bus.next_state_out), 32'd32);
      @(negedge clock) reset = 1'b1;
      @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
